// File: rtl/word_align.sv
// word_align: frame-sync word aligner with HUNT/CHECK/LOCKED acquisition.
// Ports: pclk, rst (async low), q/cal in; dout, dout_vld, sof, locked, offset, recal out.
module word_align #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter int         FRAME_LEN = 16,
  parameter int         LOCK_N    = 3,
  parameter int         LOSS_N    = 4,
  parameter int         HUNT_TO   = 1024
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] q,
  input  logic       cal,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       sof,
  output logic       locked,
  output logic [2:0] offset,
  output logic       recal
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] FLAST = FW'(FRAME_LEN - 1);
  localparam logic [15:0]   HLAST = 16'(HUNT_TO - 1);
  localparam logic [3:0]    LOCKV = 4'(LOCK_N);
  localparam logic [3:0]    LOSSV = 4'(LOSS_N);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    CHECK,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    qr_q, qrr_q;
  logic [2:0]    offset_q, offset_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    hit_q, hit_d;
  logic [3:0]    miss_q, miss_d;
  logic [15:0]   hunt_q, hunt_d;
  logic [7:0]    dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          sof_q, sof_d;
  logic          recal_q, recal_d;

  logic [15:0]   win;
  logic          any_hit;
  logic [2:0]    hit_k;
  logic          match;
  logic          expct;
  logic [2:0]    sel;

  // Older word sits in the low half, so bit index follows arrival time.
  assign win   = {qr_q, qrr_q};
  assign match = (win[offset_q +: 8] == SYNC_WORD);
  assign expct = (fcnt_q == FLAST);

  // Descending scan so the lowest matching offset wins.
  always_comb begin
    any_hit = 1'b0;
    hit_k   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_WORD) begin
        any_hit = 1'b1;
        hit_k   = 3'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    fcnt_d   = fcnt_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    hunt_d   = hunt_q;
    sof_d    = 1'b0;
    recal_d  = 1'b0;
    sel      = offset_q;
    if (!cal) begin
      state_d = IDLE;
      fcnt_d  = '0;
      hit_d   = '0;
      miss_d  = '0;
      hunt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = HUNT;
          hunt_d  = '0;
        end
        HUNT: begin
          if (any_hit) begin
            // Hit beats a coinciding timeout.
            offset_d = hit_k;
            sel      = hit_k;
            fcnt_d   = '0;
            hit_d    = 4'd1;
            miss_d   = '0;
            hunt_d   = '0;
            if (LOCK_N == 1) begin
              state_d = LOCKED;
              sof_d   = 1'b1;
            end else begin
              state_d = CHECK;
            end
          end else if (hunt_q == HLAST) begin
            recal_d = 1'b1;
            hunt_d  = '0;
          end else begin
            hunt_d = hunt_q + 16'd1;
          end
        end
        CHECK: begin
          fcnt_d = expct ? '0 : fcnt_q + 1'b1;
          if (expct) begin
            if (match) begin
              hit_d = hit_q + 4'd1;
              if (hit_d == LOCKV) begin
                state_d = LOCKED;
                miss_d  = '0;
                sof_d   = 1'b1;
              end
            end else begin
              state_d = HUNT;
              hunt_d  = '0;
            end
          end
        end
        LOCKED: begin
          fcnt_d = expct ? '0 : fcnt_q + 1'b1;
          if (expct) begin
            if (match) begin
              miss_d = '0;
              sof_d  = 1'b1;
            end else begin
              miss_d = miss_q + 4'd1;
              if (miss_d == LOSSV) begin
                state_d = HUNT;
                miss_d  = '0;
                hunt_d  = '0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    dout_d = win[sel +: 8];
    vld_d  = (state_d == LOCKED);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      qr_q     <= '0;
      qrr_q    <= '0;
      offset_q <= '0;
      fcnt_q   <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      hunt_q   <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      sof_q    <= 1'b0;
      recal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      qr_q     <= q;
      qrr_q    <= qr_q;
      offset_q <= offset_d;
      fcnt_q   <= fcnt_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      hunt_q   <= hunt_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      sof_q    <= sof_d;
      recal_q  <= recal_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign locked   = vld_q;
  assign sof      = sof_q;
  assign offset   = offset_q;
  assign recal    = recal_q;

endmodule

// File: tb/tb_word_align.sv
// tb_word_align: randomized bit-stream stimulus against a frame-level model.
// Drives word_align with shifted sync frames, cal drops and resets.
module tb_word_align;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int FL    = 16;
  localparam int LOCKN = 3;
  localparam int LOSSN = 4;
  localparam int HTO   = 1024;

  logic       pclk = 1'b0;
  logic       rst;
  logic [7:0] q;
  logic       cal;
  logic [7:0] dout;
  logic       dout_vld, sof, locked, recal;
  logic [2:0] offset;

  word_align #(
    .SYNC_WORD(SYNC), .FRAME_LEN(FL), .LOCK_N(LOCKN),
    .LOSS_N(LOSSN), .HUNT_TO(HTO)
  ) dut (
    .pclk(pclk), .rst(rst), .q(q), .cal(cal),
    .dout(dout), .dout_vld(dout_vld), .sof(sof),
    .locked(locked), .offset(offset), .recal(recal)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 hunting, 2 confirming, 3 locked.
  int         mode;
  logic [7:0] h1, h2;
  logic [2:0] m_off;
  int         anchor, hits, misses, hunt_len, cyc;
  logic [7:0] e_dout;
  logic       e_vld, e_sof, e_recal;

  logic [7:0] prev_a;
  int         shift;
  bit         saw_lock;
  bit         track_gaps;
  int         last_recal, recal_cnt;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    mode = 0; h1 = 8'h00; h2 = 8'h00; m_off = 3'd0;
    anchor = 0; hits = 0; misses = 0; hunt_len = 0;
    e_dout = 8'h00; e_vld = 0; e_sof = 0; e_recal = 0;
  endtask

  task automatic model_edge(input logic [7:0] w, input logic c);
    logic [15:0] win;
    logic [2:0]  sel;
    bit          hit;
    int          hk;
    bit          on_time;
    win = {h1, h2};
    hit = 0; hk = 0;
    for (int k = 0; k < 8; k++)
      if (!hit && win[k +: 8] == SYNC) begin hit = 1; hk = k; end
    sel = m_off;
    e_sof = 0; e_recal = 0;
    on_time = ((cyc - anchor) % FL) == 0;
    if (!c) begin
      mode = 0; hits = 0; misses = 0; hunt_len = 0;
    end else begin
      case (mode)
        0: begin mode = 1; hunt_len = 0; end
        1: begin
          if (hit) begin
            m_off = 3'(hk); sel = 3'(hk); anchor = cyc;
            hits = 1; misses = 0; hunt_len = 0;
            if (LOCKN == 1) begin mode = 3; e_sof = 1; end
            else mode = 2;
          end else begin
            hunt_len++;
            if (hunt_len == HTO) begin e_recal = 1; hunt_len = 0; end
          end
        end
        2: if (on_time) begin
          if (win[m_off +: 8] == SYNC) begin
            hits++;
            if (hits == LOCKN) begin mode = 3; misses = 0; e_sof = 1; end
          end else begin
            mode = 1; hunt_len = 0;
          end
        end
        default: if (on_time) begin
          if (win[m_off +: 8] == SYNC) begin
            misses = 0; e_sof = 1;
          end else begin
            misses++;
            if (misses == LOSSN) begin mode = 1; misses = 0; hunt_len = 0; end
          end
        end
      endcase
    end
    e_dout = win[sel +: 8];
    e_vld  = (mode == 3);
    h2 = h1; h1 = w;
    cyc++;
  endtask

  task automatic step(input logic [7:0] w, input logic c);
    q = w; cal = c;
    @(posedge pclk);
    model_edge(w, c);
    #1;
    chk("dout", dout, e_dout);
    chk("dout_vld", dout_vld, e_vld);
    chk("locked", locked, e_vld);
    chk("sof", sof, e_sof);
    chk("recal", recal, e_recal);
    chk("offset", offset, m_off);
    if (locked === 1'b1) saw_lock = 1;
    if (recal === 1'b1) begin
      recal_cnt++;
      if (track_gaps && last_recal >= 0)
        chk("recal_gap", 16'(cyc - last_recal), 16'(HTO));
      last_recal = cyc;
    end
  endtask

  // Emits aligned byte a into a bit stream delayed by `shift` bits.
  task automatic send(input logic [7:0] a, input logic c);
    logic [15:0] pair;
    pair = {a, prev_a} >> (8 - shift);
    prev_a = a;
    step(pair[7:0], c);
  endtask

  // 00/FF runs cannot form the alternating sync pattern at any alignment.
  function automatic logic [7:0] filler();
    return ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
  endfunction

  task automatic frames(input int n, input int bad, input logic c);
    for (int f = 0; f < n; f++) begin
      send((f < bad) ? filler() : SYNC, c);
      for (int i = 1; i < FL; i++) send(filler(), c);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_dout"}, dout, 16'h0);
    chk({tag, "_vld"}, dout_vld, 16'h0);
    chk({tag, "_sof"}, sof, 16'h0);
    chk({tag, "_locked"}, locked, 16'h0);
    chk({tag, "_offset"}, offset, 16'h0);
    chk({tag, "_recal"}, recal, 16'h0);
  endtask

  initial begin
    rst = 1'b0; cal = 1'b0; q = 8'h00;
    cyc = 0; prev_a = 8'h00; shift = 3;
    saw_lock = 0; track_gaps = 0; last_recal = -1; recal_cnt = 0;
    model_reset();
    #1;
    check_reset_outs("por");
    #20;
    @(negedge pclk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) send(filler(), 1'b0);
    frames(5, 0, 1'b1);
    chk("acq_offset", offset, 16'd3);
    chk("acq_locked", locked, 16'd1);

    frames(1, 0, 1'b1);
    frames(3, 3, 1'b1);
    frames(2, 0, 1'b1);
    chk("hold_3miss", locked, 16'd1);

    frames(4, 4, 1'b1);
    chk("drop_4miss", locked, 16'd0);
    frames(5, 0, 1'b1);
    chk("reacq_miss", locked, 16'd1);

    send(filler(), 1'b0);
    chk("cal_drop", locked, 16'd0);
    send(filler(), 1'b0);
    frames(5, 0, 1'b1);
    chk("reacq_cal", locked, 16'd1);

    send(SYNC, 1'b1);
    for (int i = 0; i < 6; i++) send(filler(), 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outs("midrst");
    model_reset();
    prev_a = 8'h00;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b1;
    frames(4, 0, 1'b1);
    chk("reacq_rst", locked, 16'd1);

    send(filler(), 1'b0);
    saw_lock = 0;
    frames(1, 0, 1'b1);
    frames(4, 4, 1'b1);
    chk("check_fail_nolock", 16'(saw_lock), 16'd0);

    send(filler(), 1'b0);
    saw_lock = 0; track_gaps = 1; last_recal = -1; recal_cnt = 0;
    for (int i = 0; i < 3080; i++) send(filler(), 1'b1);
    chk("recal_count", 16'(recal_cnt), 16'd3);
    chk("nosync_nolock", 16'(saw_lock), 16'd0);
    track_gaps = 0;

    shift = $urandom_range(0, 7);
    for (int f = 0; f < 40; f++) begin
      logic c;
      c = ($urandom_range(0, 49) != 0);
      send(($urandom_range(0, 3) != 0) ? SYNC : 8'($urandom), c);
      for (int i = 1; i < FL; i++) send(8'($urandom), c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
